// File: rtl/signal_rx_pkg.sv
// Shared types and constants for the UART receive path.
package signal_rx_pkg;

    typedef logic [7:0] byte_t;

    localparam int CLOCK_FREQ_HZ  = 16_000_000;
    localparam int BAUD_RATE      = 1_000_000;
    localparam int CLKS_PER_BIT   = CLOCK_FREQ_HZ / BAUD_RATE;
    localparam int HALF_BIT       = CLKS_PER_BIT / 2;
    localparam int UART_DATA_BITS = 8;
    localparam int BAUD_W         = $clog2(CLKS_PER_BIT) + 1;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/signal_rx_if.sv
// Byte hand-off from the receiver to its consumer, plus status strobes.
interface signal_rx_if;
    import signal_rx_pkg::*;

    byte_t rx_data;
    logic  rx_valid;
    logic  rx_ready;
    logic  frame_err;
    logic  overrun;
    logic  rx_busy;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, rx_busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, rx_busy,
        output rx_ready
    );
endinterface

// File: rtl/signal_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; resets to 1
// so an idle-high line does not look like activity coming out of reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: simple two-stage shift.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops with synchronous active-low reset to idle-high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/signal_rx.sv
// UART receiver: 8N1 frames, LSB first, valid/ready byte hand-off.
//
// state        | meaning
// -------------+----------------------------------------------------
// RX_IDLE      | line idle, waiting for a falling edge on rx_s
// RX_START     | counting to mid start bit to reject glitches
// RX_DATA      | sampling 8 data bits at mid-bit
// RX_STOP      | sampling the stop bit at mid-bit, then delivering
// RX_WAIT_HIGH | framing error seen; wait for line to return high
module signal_rx
    import signal_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    signal_rx_if.master bus
);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF_BIT - 1);

    rx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    byte_t             shift_q, shift_d;
    byte_t             data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;

    logic rx_s;
    logic half_hit, full_hit, last_bit;
    logic stop_sample, stop_good, stop_bad;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign half_hit    = (baud_cnt_q == HALF_LAST);
    assign full_hit    = (baud_cnt_q == BAUD_LAST);
    assign last_bit    = (bit_cnt_q == 3'(UART_DATA_BITS - 1));
    assign stop_sample = (state_q == RX_STOP) && full_hit;
    assign stop_good   = stop_sample &&  rx_s;
    assign stop_bad    = stop_sample && !rx_s;

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= RX_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RX_IDLE:      if (!rx_s) state_d = RX_START;
            RX_START:     if (half_hit) state_d = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:      if (full_hit && last_bit) state_d = RX_STOP;
            RX_STOP:      if (full_hit) state_d = rx_s ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_s) state_d = RX_IDLE;
            default:      state_d = RX_IDLE;
        endcase
    end

    // Counters, shift register, and the delivery/accept handshake.
    always_comb begin
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                if (!rx_s) baud_cnt_d = '0;
            end
            RX_START: begin
                if (half_hit) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            RX_DATA: begin
                if (full_hit) begin
                    shift_d    = {rx_s, shift_q[7:1]};
                    baud_cnt_d = '0;
                    if (!last_bit) bit_cnt_d = bit_cnt_q + 3'd1;
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            RX_STOP: begin
                if (full_hit) baud_cnt_d = '0;
                else          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
            end
            RX_WAIT_HIGH: begin
                baud_cnt_d = '0;
            end
            default: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase

        // A delivery in the same cycle as an accept keeps rx_valid high
        // with the new byte; only a full holding register drops the byte.
        if (stop_good) begin
            if (!valid_q || bus.rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && bus.rx_ready) begin
            valid_d = 1'b0;
        end

        ferr_d = stop_bad;
    end

    // Outputs, all registered except busy which is decoded from state.
    always_comb begin
        bus.rx_data   = data_q;
        bus.rx_valid  = valid_q;
        bus.frame_err = ferr_q;
        bus.overrun   = ovr_q;
        bus.rx_busy   = (state_q != RX_IDLE);
    end
endmodule

// File: tb/tb_signal_rx.sv
// Directed bench for signal_rx with 16 clocks per bit.
module tb_signal_rx;
    import signal_rx_pkg::*;

    localparam int BIT = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;

    signal_rx_if bus ();

    signal_rx dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Monitor state, sampled on the falling edge.
    byte_t got_q[$];
    int    ov_cnt    = 0;
    int    fe_cnt    = 0;
    int    both_cnt  = 0;
    int    valid_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
            if (bus.overrun)   ov_cnt++;
            if (bus.frame_err) fe_cnt++;
            if (bus.overrun && bus.frame_err) both_cnt++;
            if (bus.rx_valid)  valid_cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input byte_t b, input logic stop_bit, input int nbits);
        rx = 1'b0;
        cycles(BIT);
        for (int i = 0; i < nbits; i++) begin
            rx = b[i];
            cycles(BIT);
        end
        if (nbits == 8) begin
            rx = stop_bit;
            cycles(BIT);
        end
    endtask

    task automatic accept_one();
        bus.rx_ready = 1'b1;
        cycles(1);
        bus.rx_ready = 1'b0;
    endtask

    int ov0, fe0, vc0, n0;
    logic any_flag;

    initial begin
        bus.rx_ready = 1'b0;
        any_flag = 1'b0;

        // 1: reset held with rx toggling, then idle line
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            rx = ~rx;
            cycles(1);
            if (bus.frame_err || bus.overrun) any_flag = 1'b1;
        end
        check("rst_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_data",  32'(bus.rx_data),  32'h00);
        check("rst_busy",  32'(bus.rx_busy),  32'd0);
        check("rst_flags", 32'(any_flag),     32'd0);
        rx = 1'b1;
        rst = 1'b1;
        vc0 = valid_cyc;
        cycles(200);
        check("idle_valid_cycles", 32'(valid_cyc - vc0), 32'd0);
        check("idle_busy", 32'(bus.rx_busy), 32'd0);

        // 2: 0xA5 held until accepted
        send_bits(8'hA5, 1'b1, 8);
        cycles(30);
        check("a5_valid", 32'(bus.rx_valid), 32'd1);
        check("a5_data",  32'(bus.rx_data),  32'hA5);
        accept_one();
        check("a5_cleared", 32'(bus.rx_valid), 32'd0);

        // 3: back-to-back 0x55, 0x0F with ready tied high
        ov0 = ov_cnt; fe0 = fe_cnt; n0 = got_q.size();
        bus.rx_ready = 1'b1;
        send_bits(8'h55, 1'b1, 8);
        send_bits(8'h0F, 1'b1, 8);
        cycles(20);
        bus.rx_ready = 1'b0;
        check("b2b_count", 32'(got_q.size() - n0), 32'd2);
        if (got_q.size() >= n0 + 2) begin
            check("b2b_first",  32'(got_q[n0]),     32'h55);
            check("b2b_second", 32'(got_q[n0 + 1]), 32'h0F);
        end
        check("b2b_overrun", 32'(ov_cnt - ov0), 32'd0);
        check("b2b_ferr",    32'(fe_cnt - fe0), 32'd0);
        check("b2b_valid_after", 32'(bus.rx_valid), 32'd0);

        // 4: back-to-back 0x12, 0x34 with ready low -> overrun
        ov0 = ov_cnt;
        send_bits(8'h12, 1'b1, 8);
        send_bits(8'h34, 1'b1, 8);
        cycles(20);
        check("ovr_valid", 32'(bus.rx_valid), 32'd1);
        check("ovr_data",  32'(bus.rx_data),  32'h12);
        check("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
        accept_one();
        check("ovr_cleared", 32'(bus.rx_valid), 32'd0);

        // 5: bad stop bit on 0xFF, line held low, then 0x3C
        fe0 = fe_cnt; vc0 = valid_cyc;
        send_bits(8'hFF, 1'b0, 8);
        rx = 1'b0;
        cycles(40);
        check("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
        check("ferr_no_valid", 32'(valid_cyc - vc0), 32'd0);
        check("ferr_wait_busy", 32'(bus.rx_busy), 32'd1);
        rx = 1'b1;
        cycles(20);
        check("ferr_back_idle", 32'(bus.rx_busy), 32'd0);
        check("ferr_no_retrigger", 32'(fe_cnt - fe0), 32'd1);
        send_bits(8'h3C, 1'b1, 8);
        cycles(20);
        check("after_ferr_valid", 32'(bus.rx_valid), 32'd1);
        check("after_ferr_data",  32'(bus.rx_data),  32'h3C);
        accept_one();

        // 6a: 6-cycle glitch on idle line
        ov0 = ov_cnt; fe0 = fe_cnt; vc0 = valid_cyc;
        rx = 1'b0;
        cycles(6);
        rx = 1'b1;
        cycles(20);
        check("glitch_busy",  32'(bus.rx_busy), 32'd0);
        check("glitch_valid", 32'(valid_cyc - vc0), 32'd0);
        check("glitch_flags", 32'((ov_cnt - ov0) + (fe_cnt - fe0)), 32'd0);

        // 6b: reset during bit 4, then clean 0x81
        send_bits(8'hF0, 1'b1, 4);
        cycles(BIT / 2);
        check("mid_frame_busy", 32'(bus.rx_busy), 32'd1);
        rst = 1'b0;
        rx  = 1'b1;
        cycles(3);
        check("mid_rst_busy",  32'(bus.rx_busy),  32'd0);
        check("mid_rst_valid", 32'(bus.rx_valid), 32'd0);
        rst = 1'b1;
        vc0 = valid_cyc;
        cycles(200);
        check("lost_frame_valid", 32'(valid_cyc - vc0), 32'd0);
        send_bits(8'h81, 1'b1, 8);
        cycles(20);
        check("rst_recover_valid", 32'(bus.rx_valid), 32'd1);
        check("rst_recover_data",  32'(bus.rx_data),  32'h81);
        accept_one();

        check("flags_never_both", 32'(both_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
